// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU flags output stage:
//   - flag bit positions inside the 6-bit flags vector (CF..OF)
//   - operand-size encodings used on the size inputs
//   - flags_t, the 6-bit flags vector type
//   - merge_flags(), the masked merge of new flags into the current flags
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int NUM_FLAGS = 6;

  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 1;
  localparam int FLAG_AF = 2;
  localparam int FLAG_ZF = 3;
  localparam int FLAG_SF = 4;
  localparam int FLAG_OF = 5;

  localparam logic [1:0] SIZE_8  = 2'b00;
  localparam logic [1:0] SIZE_16 = 2'b01;
  localparam logic [1:0] SIZE_W  = 2'b10;

  typedef logic [NUM_FLAGS-1:0] flags_t;

  // Bits set in mask take the freshly computed value, the rest keep cur.
  function automatic flags_t merge_flags(flags_t cur, flags_t raw, flags_t mask);
    return (cur & ~mask) | (raw & mask);
  endfunction

endpackage

// File: rtl/alu_flags_calc.sv
// -----------------------------------------------------------------------------
// alu_flags_calc
// Purely combinational x86 arithmetic-flag computation from the adder's sum
// and per-bit carry vector.
//   sum_i    [WIDTH-1:0]  adder sum
//   carry_i  [WIDTH:0]    carry into each bit, carry_i[WIDTH] is carry-out
//   size_i   [1:0]        operand size (SIZE_8 / SIZE_16 / SIZE_W, 2'b11 = SIZE_W)
//   sub_i                 operation was a + ~b + 1 (CF/AF reported as borrow)
//   flags_o  [5:0]        raw flags {OF,SF,ZF,AF,PF,CF}
// WIDTH must be at least 16.
// -----------------------------------------------------------------------------
module alu_flags_calc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] sum_i,
  input  logic [WIDTH:0]   carry_i,
  input  logic [1:0]       size_i,
  input  logic             sub_i,
  output logic [5:0]       flags_o
);

  logic c_out;   // carry out of the operand's MSB
  logic c_msb;   // carry into the operand's MSB
  logic zero;
  logic sign;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    c_out = carry_i[WIDTH];
    c_msb = carry_i[WIDTH-1];
    zero  = (sum_i == '0);
    sign  = sum_i[WIDTH-1];
    case (size_i)
      SIZE_8: begin
        c_out = carry_i[8];
        c_msb = carry_i[7];
        zero  = (sum_i[7:0] == 8'h00);
        sign  = sum_i[7];
      end
      SIZE_16: begin
        c_out = carry_i[16];
        c_msb = carry_i[15];
        zero  = (sum_i[15:0] == 16'h0000);
        sign  = sum_i[15];
      end
      default: ;  // SIZE_W and the illegal 2'b11 both use the full width
    endcase

    flags_o          = '0;
    flags_o[FLAG_CF] = c_out ^ sub_i;
    flags_o[FLAG_PF] = ~^sum_i[7:0];   // parity always on the low byte
    flags_o[FLAG_AF] = carry_i[4] ^ sub_i;
    flags_o[FLAG_ZF] = zero;
    flags_o[FLAG_SF] = sign;
    flags_o[FLAG_OF] = c_out ^ c_msb;
  end

  // Only a handful of carry bits matter for the supported sizes.
  logic unused_carry;
  assign unused_carry = ^carry_i;

endmodule

// File: rtl/alu_flags_stage.sv
// -----------------------------------------------------------------------------
// alu_flags_stage
// Registered output stage behind the Kogge-Stone adder. Captures the sum, the
// raw flags and the write mask at the input handshake, presents the result and
// the merged flags to writeback, and commits the merged flags into the
// architectural flags register on the output handshake.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   in_valid/in_ready input handshake
//   in_sum, in_carry  adder sum and carry vector (in_carry[WIDTH] = carry-out)
//   in_size, in_sub   operand size code, subtract flag
//   in_mask           flags written by this op
//   out_valid/out_ready output handshake
//   out_result        registered sum
//   out_flags         flags_q merged with this op's raw flags under its mask
//   flags_q           architectural flags
//   flags_ld/flags_ld_data  direct flags load (wins over an output handshake)
//   flush             synchronous kill of all buffered ops and same-cycle input
//
// Build option: define ALU_FLAGS_SKID_EN for a two-entry buffer (output
// register plus skid register) with a registered in_ready. Without it the
// stage holds a single entry and in_ready is combinational.
// -----------------------------------------------------------------------------
module alu_flags_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH:0]   in_carry,
  input  logic [1:0]       in_size,
  input  logic             in_sub,
  input  logic [5:0]       in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [5:0]       out_flags,
  output logic [5:0]       flags_q,
  input  logic             flags_ld,
  input  logic [5:0]       flags_ld_data,
  input  logic             flush
);

  flags_t raw_flags;

  alu_flags_calc #(.WIDTH(WIDTH)) u_calc (
    .sum_i   (in_sum),
    .carry_i (in_carry),
    .size_i  (in_size),
    .sub_i   (in_sub),
    .flags_o (raw_flags)
  );

  // Output register
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  flags_t           out_raw_q, out_raw_d;
  flags_t           out_mask_q, out_mask_d;
  flags_t           flags_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = out_valid_q & out_ready;

  // Merge against the live flags_q so a dependent op right behind this one
  // sees the flags this op commits.
  assign out_flags  = merge_flags(flags_q, out_raw_q, out_mask_q);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

`ifdef ALU_FLAGS_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_result_q, skid_result_d;
  flags_t           skid_raw_q, skid_raw_d;
  flags_t           skid_mask_q, skid_mask_d;
  logic             in_ready_q;

  assign in_ready = in_ready_q;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_raw_d     = out_raw_q;
    out_mask_d    = out_mask_q;
    skid_valid_d  = skid_valid_q;
    skid_result_d = skid_result_q;
    skid_raw_d    = skid_raw_q;
    skid_mask_d   = skid_mask_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_fire) begin
      // Output slot frees this edge: the skid entry is older than any input,
      // and in_ready is low whenever the skid is occupied.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_result_d = skid_result_q;
        out_raw_d    = skid_raw_q;
        out_mask_d   = skid_mask_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d  = 1'b1;
        out_result_d = in_sum;
        out_raw_d    = raw_flags;
        out_mask_d   = in_mask;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (in_fire) begin
      // Output stalled: park the accepted op in the skid register.
      skid_valid_d  = 1'b1;
      skid_result_d = in_sum;
      skid_raw_d    = raw_flags;
      skid_mask_d   = in_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q  <= 1'b0;
      skid_result_q <= '0;
      skid_raw_q    <= '0;
      skid_mask_q   <= '0;
      in_ready_q    <= 1'b1;
    end else begin
      skid_valid_q  <= skid_valid_d;
      skid_result_q <= skid_result_d;
      skid_raw_q    <= skid_raw_d;
      skid_mask_q   <= skid_mask_d;
      in_ready_q    <= ~skid_valid_d;
    end
  end
`else
  assign in_ready = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_raw_d    = out_raw_q;
    out_mask_d   = out_mask_q;
    if (flush) begin
      out_valid_d  = 1'b0;
    end else if (in_fire) begin
      out_valid_d  = 1'b1;
      out_result_d = in_sum;
      out_raw_d    = raw_flags;
      out_mask_d   = in_mask;
    end else if (out_fire) begin
      out_valid_d  = 1'b0;
    end
  end
`endif

  // A direct load overrides the handshake commit; flush never touches flags.
  always_comb begin
    flags_d = flags_q;
    if (out_fire) flags_d = out_flags;
    if (flags_ld) flags_d = flags_ld_data;
  end

  // NOTE: the data registers are reset too, so out_result reads 0 out of reset
  // and no X can leak into out_flags before the first op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_raw_q    <= '0;
      out_mask_q   <= '0;
      flags_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state, so every flop
      // samples pre-edge values regardless of statement order.
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_raw_q    <= out_raw_d;
      out_mask_q   <= out_mask_d;
      flags_q      <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_flags_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_flags_stage
// Self-checking bench for alu_flags_stage (WIDTH = 32). The driver presents
// operands a/b; the bench emulates the adder to produce sum and carry vector,
// and an independent arithmetic model derives the expected flags from a, b and
// the operand size. Accepted ops are pushed into a scoreboard queue; the
// monitor pops and compares on every output handshake and tracks flags_q.
// Build with +define+ALU_FLAGS_SKID_EN to exercise the skid variant.
// -----------------------------------------------------------------------------
module tb_alu_flags_stage;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH:0]   in_carry;
  logic [1:0]       in_size;
  logic             in_sub;
  logic [5:0]       in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [5:0]       out_flags;
  logic [5:0]       flags_q;
  logic             flags_ld;
  logic [5:0]       flags_ld_data;
  logic             flush;

  alu_flags_stage #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sum        (in_sum),
    .in_carry      (in_carry),
    .in_size       (in_size),
    .in_sub        (in_sub),
    .in_mask       (in_mask),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_flags     (out_flags),
    .flags_q       (flags_q),
    .flags_ld      (flags_ld),
    .flags_ld_data (flags_ld_data),
    .flush         (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [5:0]  raw;
    logic [5:0]  mask;
    bit          lit_en;
    logic [5:0]  lit;
  } exp_t;

  exp_t       sb_q[$];
  logic [5:0] model_flags;
  int         n_checks;
  int         n_errors;

  // Operation currently presented on the input port
  logic [31:0] op_a, op_b;
  bit          op_lit_en;
  logic [5:0]  op_lit;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Flags from the operands by plain integer arithmetic on n-bit values.
  function automatic logic [5:0] ref_flags(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub, input logic [1:0] size);
    int     n;
    longint full, hb, ua, ub, sa, sb, ures, sres, r;
    logic   cf, pf, af, zf, sf, of_;
    logic [7:0] lb;
    n    = (size == 2'b00) ? 8 : (size == 2'b01) ? 16 : 32;
    full = longint'(1) << n;
    hb   = longint'(1) << (n - 1);
    ua   = longint'(a) & (full - 1);
    ub   = longint'(b) & (full - 1);
    sa   = (ua >= hb) ? ua - full : ua;
    sb   = (ub >= hb) ? ub - full : ub;
    ures = sub ? ua - ub : ua + ub;
    sres = sub ? sa - sb : sa + sb;
    r    = ures & (full - 1);
    cf   = sub ? (ua < ub) : (ures >= full);
    af   = sub ? (a[3:0] < b[3:0]) : ((int'(a[3:0]) + int'(b[3:0])) > 15);
    of_  = (sres >= hb) || (sres < -hb);
    zf   = (r == 0);
    sf   = ((r >> (n - 1)) & 1) != 0;
    lb   = r[7:0];
    pf   = ~^lb;
    return {of_, sf, zf, af, pf, cf};
  endfunction

  // Drive the adder's outputs for a op b (subtract = a + ~b + 1).
  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [1:0] size, input logic [5:0] mask,
                        input bit lit_en, input logic [5:0] lit);
    logic [31:0] bp;
    logic [32:0] full;
    bp   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bp} + {32'd0, sub};
    for (int i = 0; i < 32; i++) in_carry[i] = full[i] ^ a[i] ^ bp[i];
    in_carry[32] = full[32];
    in_sum    = full[31:0];
    in_sub    = sub;
    in_size   = size;
    in_mask   = mask;
    op_a      = a;
    op_b      = b;
    op_lit_en = lit_en;
    op_lit    = lit;
  endtask

  task automatic set_random_op();
    logic [31:0] a, b;
    int          pick;
    a    = $urandom;
    pick = $urandom_range(0, 7);
    case (pick)
      0:       b = a;               // zero result on subtract
      1:       b = 32'h0000_0001;
      2:       begin a = 32'h7FFF_FFFF; b = 32'h0000_0001; end
      3:       begin a = 32'h0000_807F; b = 32'h0000_0081; end
      default: b = $urandom;
    endcase
    set_op(a, b, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           6'($urandom_range(0, 63)), 1'b0, 6'h00);
  endtask

  // Called at a negedge; holds the op until accepted, returns at a negedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [1:0] size, input logic [5:0] mask,
                       input bit lit_en, input logic [5:0] lit);
    bit acc;
    acc = 1'b0;
    set_op(a, b, sub, size, mask, lit_en, lit);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      #4;
      acc = in_ready && !flush;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!acc) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor / scoreboard: samples 1 time unit before each rising edge and
  // applies what that edge will do to the reference state.
  always begin
    exp_t       e;
    logic [5:0] nf, ef;
    bit         exp_rdy;
    @(negedge clk);
    #4;
    if (!rst_n) begin
      sb_q.delete();
      model_flags = 6'h00;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_flags_q", 64'(flags_q), 64'd0);
    end else begin
      check("flags_q", 64'(flags_q), 64'(model_flags));
      check("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
`ifdef ALU_FLAGS_SKID_EN
      exp_rdy = sb_q.size() < 2;
`else
      exp_rdy = (sb_q.size() == 0) || out_ready;
`endif
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      nf = model_flags;
      if (out_valid && out_ready && sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        ef = (model_flags & ~e.mask) | (e.raw & e.mask);
        check("out_result", 64'(out_result), 64'(e.result));
        check("out_flags", 64'(out_flags), 64'(ef));
        if (e.lit_en) check("out_flags_vector", 64'(out_flags), 64'(e.lit));
        nf = ef;
      end
      if (flags_ld) nf = flags_ld_data;
      if (flush) sb_q.delete();
      if (in_valid && in_ready && !flush) begin
        e.result = in_sub ? op_a - op_b : op_a + op_b;
        e.raw    = ref_flags(op_a, op_b, in_sub, in_size);
        e.mask   = in_mask;
        e.lit_en = op_lit_en;
        e.lit    = op_lit;
        sb_q.push_back(e);
      end
      model_flags = nf;
    end
  end

  initial begin
    int         acc;
    logic [5:0] saved;
    n_checks      = 0;
    n_errors      = 0;
    model_flags   = 6'h00;
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    flags_ld      = 1'b0;
    flags_ld_data = 6'h00;
    flush         = 1'b0;
    set_op(32'h0, 32'h0, 1'b0, 2'b00, 6'h00, 1'b0, 6'h00);
    repeat (2) @(negedge clk);
    check("reset_out_result", 64'(out_result), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 8-bit add 0x7F + 0x01
    issue(32'h7F, 32'h01, 1'b0, 2'b00, 6'h3F, 1'b1, 6'b110100);
    // 32-bit subtract 5 - 5
    issue(32'd5, 32'd5, 1'b1, 2'b10, 6'h3F, 1'b1, 6'b001010);
    drain();

    // INC-style op keeps CF
    flags_ld = 1'b1; flags_ld_data = 6'b000001;
    @(negedge clk);
    flags_ld = 1'b0;
    issue(32'h10, 32'h01, 1'b0, 2'b00, 6'b111110, 1'b1, 6'b000011);
    repeat (2) @(negedge clk);
    check("inc_cf_kept", 64'(flags_q[0]), 64'd1);

    // Stall with continuous input
    out_ready = 1'b0;
    acc = 0;
    set_random_op();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4;
      if (in_ready) acc++;
      @(negedge clk);
      if (in_ready) set_random_op();
    end
    in_valid = 1'b0;
`ifdef ALU_FLAGS_SKID_EN
    check("stall_accepts", 64'(acc), 64'd2);
`else
    check("stall_accepts", 64'(acc), 64'd1);
`endif
    out_ready = 1'b1;
    drain();

    // Flush while full; the simultaneous input must be dropped
    out_ready = 1'b0;
    set_random_op();
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    saved    = flags_q;
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_flags_q", 64'(flags_q), 64'(saved));

    // Direct load coinciding with an output handshake
    out_ready = 1'b1;
    issue(32'h1234, 32'h4321, 1'b0, 2'b01, 6'h3F, 1'b0, 6'h00);
    flags_ld = 1'b1; flags_ld_data = 6'b101010;
    @(negedge clk);
    flags_ld = 1'b0;
    check("ld_wins", 64'(flags_q), 64'(6'b101010));

    // Asynchronous reset in the middle of a stall
    flags_ld = 1'b1; flags_ld_data = 6'b111111;
    @(negedge clk);
    flags_ld  = 1'b0;
    out_ready = 1'b0;
    issue(32'hABCD, 32'h1111, 1'b1, 2'b10, 6'h3F, 1'b0, 6'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_flags_q", 64'(flags_q), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    issue(32'h7F, 32'h01, 1'b0, 2'b00, 6'h3F, 1'b1, 6'b110100);
    drain();

    // Randomized traffic with backpressure, loads and flushes
    for (int i = 0; i < 400; i++) begin
      out_ready     = ($urandom_range(0, 9) < 7);
      flags_ld      = ($urandom_range(0, 19) == 0);
      flags_ld_data = 6'($urandom_range(0, 63));
      flush         = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) < 7) begin
        set_random_op();
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    flags_ld  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
